depth_tile_test: RTL and testbench

- Per-tile depth test stage directly downstream of plane_eq.
- Consumes one SIZE x SIZE block of interpolated 18-bit z values plus a coverage mask per transaction.
- Compares each sample against an internal on-chip tile depth buffer, writes back passing depths, and emits a per-sample pass mask to the shading stage.
- Owns depth buffer clearing: automatic after reset, and on request.

---
 rtl/depth_tile_test.sv | 205 ++++++++++++++++++++
 tb/tb_depth_tile_test.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depth_tile_test.sv
// Per-tile depth test with an on-chip tile depth buffer that it clears after reset and on request.
// Define DEPTH_TEST_LEQUAL_EN to make equal depths pass (less-or-equal compare).
module depth_tile_test #(
  parameter int SIZE    = 2,
  parameter int TILES_X = 4,
  parameter int TILES_Y = 4,
  localparam int XW = (TILES_X > 1) ? $clog2(TILES_X) : 1,
  localparam int YW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [XW-1:0]                   in_tile_x,
  input  logic [YW-1:0]                   in_tile_y,
  input  logic [SIZE-1:0][SIZE-1:0][17:0] in_z,
  input  logic [SIZE-1:0][SIZE-1:0]       in_cover,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [XW-1:0]                   out_tile_x,
  output logic [YW-1:0]                   out_tile_y,
  output logic [SIZE-1:0][SIZE-1:0]       out_mask,
  output logic [SIZE-1:0][SIZE-1:0][17:0] out_z,
  input  logic                            clear_req,
  input  logic [17:0]                     clear_val,
  output logic                            busy,
  output logic                            clear_done
);
  localparam int N  = TILES_X * TILES_Y;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef logic [SIZE-1:0][SIZE-1:0][17:0] tile_z_t;
  typedef logic [SIZE-1:0][SIZE-1:0]       tile_m_t;
  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_t;

  function automatic logic depth_pass(input logic cov, input logic [17:0] z, input logic [17:0] s);
`ifdef DEPTH_TEST_LEQUAL_EN
    return cov && (z <= s);
`else
    return cov && (z < s);
`endif
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [17:0]   clr_val_q, clr_val_d;
  logic          clear_done_q, clear_done_d;

  logic          vld_p1_q, vld_p1_d;
  logic [XW-1:0] tx_p1_q, tx_p1_d;
  logic [YW-1:0] ty_p1_q, ty_p1_d;
  logic [AW-1:0] addr_p1_q, addr_p1_d;
  tile_z_t       z_p1_q, z_p1_d;
  tile_m_t       cov_p1_q, cov_p1_d;
  logic          fwd_p1_q, fwd_p1_d;
  tile_z_t       fwd_z_p1_q, fwd_z_p1_d;
  tile_z_t       rd_p1_q;

  logic          out_valid_q, out_valid_d;
  logic [XW-1:0] tx_p2_q, tx_p2_d;
  logic [YW-1:0] ty_p2_q, ty_p2_d;
  tile_m_t       mask_p2_q, mask_p2_d;
  tile_z_t       z_p2_q, z_p2_d;

  tile_z_t       mem [N];
  logic          advance, accept, s1_we, mem_we;
  logic [AW-1:0] in_addr, mem_waddr;
  tile_z_t       stored_p1, merged_p1, clr_tile, mem_wdata;
  tile_m_t       pass_p1;

  assign in_addr = AW'(int'(in_tile_y) * TILES_X + int'(in_tile_x));

  always_comb begin
    advance   = !out_valid_q || out_ready;
    in_ready  = (state_q == ST_RUN) && advance;
    accept    = in_valid && in_ready;
    // A same-tile write from the previous transaction overrides the stale buffer read.
    stored_p1 = fwd_p1_q ? fwd_z_p1_q : rd_p1_q;
    pass_p1   = '0;
    merged_p1 = stored_p1;
    clr_tile  = '0;
    for (int y = 0; y < SIZE; y++) begin
      for (int x = 0; x < SIZE; x++) begin
        pass_p1[y][x]  = depth_pass(cov_p1_q[y][x], z_p1_q[y][x], stored_p1[y][x]);
        if (pass_p1[y][x]) merged_p1[y][x] = z_p1_q[y][x];
        clr_tile[y][x] = clr_val_q;
      end
    end
    s1_we     = vld_p1_q && advance;
    mem_we    = s1_we || (state_q == ST_CLEAR);
    mem_waddr = (state_q == ST_CLEAR) ? clr_addr_q : addr_p1_q;
    mem_wdata = (state_q == ST_CLEAR) ? clr_tile : merged_p1;
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_val_d    = clr_val_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == AW'(N - 1)) begin
          state_d      = ST_RUN;
          clr_addr_d   = '0;
          clear_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d   = ST_DRAIN;
          clr_val_d = clear_val;
        end
      end
      ST_DRAIN: begin
        if (!vld_p1_q && !out_valid_q) state_d = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    vld_p1_d   = vld_p1_q;
    tx_p1_d    = tx_p1_q;
    ty_p1_d    = ty_p1_q;
    addr_p1_d  = addr_p1_q;
    z_p1_d     = z_p1_q;
    cov_p1_d   = cov_p1_q;
    fwd_p1_d   = fwd_p1_q;
    fwd_z_p1_d = fwd_z_p1_q;
    if (advance) vld_p1_d = accept;
    if (accept) begin
      tx_p1_d    = in_tile_x;
      ty_p1_d    = in_tile_y;
      addr_p1_d  = in_addr;
      z_p1_d     = in_z;
      cov_p1_d   = in_cover;
      fwd_p1_d   = s1_we && (addr_p1_q == in_addr);
      fwd_z_p1_d = merged_p1;
    end
    out_valid_d = advance ? vld_p1_q : out_valid_q;
    tx_p2_d     = tx_p2_q;
    ty_p2_d     = ty_p2_q;
    mask_p2_d   = mask_p2_q;
    z_p2_d      = z_p2_q;
    if (s1_we) begin
      tx_p2_d   = tx_p1_q;
      ty_p2_d   = ty_p1_q;
      mask_p2_d = pass_p1;
      z_p2_d    = z_p1_q;
    end
  end

  // Stage p0 -> p1: buffer write-back and synchronous read of the accepted tile
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (accept) rd_p1_q <= mem[in_addr];
  end

  always_ff @(posedge clk) begin
    tx_p1_q    <= tx_p1_d;
    ty_p1_q    <= ty_p1_d;
    addr_p1_q  <= addr_p1_d;
    z_p1_q     <= z_p1_d;
    cov_p1_q   <= cov_p1_d;
    fwd_p1_q   <= fwd_p1_d;
    fwd_z_p1_q <= fwd_z_p1_d;
  end

  // Stage p1 -> p2: output register, control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      clr_val_q    <= 18'h3FFFF;
      clear_done_q <= 1'b0;
      vld_p1_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      tx_p2_q      <= '0;
      ty_p2_q      <= '0;
      mask_p2_q    <= '0;
      z_p2_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_val_q    <= clr_val_d;
      clear_done_q <= clear_done_d;
      vld_p1_q     <= vld_p1_d;
      out_valid_q  <= out_valid_d;
      tx_p2_q      <= tx_p2_d;
      ty_p2_q      <= ty_p2_d;
      mask_p2_q    <= mask_p2_d;
      z_p2_q       <= z_p2_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_tile_x = tx_p2_q;
  assign out_tile_y = ty_p2_q;
  assign out_mask   = mask_p2_q;
  assign out_z      = z_p2_q;
  assign busy       = (state_q != ST_RUN);
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_depth_tile_test.sv
// Scoreboard bench for depth_tile_test: accepted transactions are scored against a per-sample depth model.
module tb_depth_tile_test;
  localparam int SIZE = 2;
  localparam int TX = 4;
  localparam int TY = 4;
  localparam int NS = SIZE * SIZE;
  localparam int NT = TX * TY;

  typedef logic [SIZE-1:0][SIZE-1:0][17:0] zt_t;
  typedef logic [SIZE-1:0][SIZE-1:0]       mt_t;
  typedef struct {
    logic [1:0] tx;
    logic [1:0] ty;
    mt_t        mask;
    zt_t        z;
    int         acc;
    bit         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_tile_x = '0;
  logic [1:0]  in_tile_y = '0;
  zt_t         in_z = '0;
  mt_t         in_cover = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_tile_x, out_tile_y;
  mt_t         out_mask;
  zt_t         out_z;
  logic        clear_req = 1'b0;
  logic [17:0] clear_val = '0;
  logic        busy, clear_done;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   lat_next = 1'b0;
  bit   front_seen = 1'b0;
  exp_t q[$];
  exp_t trk_e;
  int   trk_a;
  logic [17:0] ref_buf [NT][NS];

  depth_tile_test #(.SIZE(SIZE), .TILES_X(TX), .TILES_Y(TY)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_tile_x(in_tile_x), .in_tile_y(in_tile_y),
    .in_z(in_z), .in_cover(in_cover),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tile_x(out_tile_x), .out_tile_y(out_tile_y),
    .out_mask(out_mask), .out_z(out_z),
    .clear_req(clear_req), .clear_val(clear_val),
    .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit closer(input logic [17:0] z, input logic [17:0] s);
`ifdef DEPTH_TEST_LEQUAL_EN
    return z <= s;
`else
    return z < s;
`endif
  endfunction

  function automatic void model_fill(input logic [17:0] v);
    for (int a = 0; a < NT; a++)
      for (int i = 0; i < NS; i++) ref_buf[a][i] = v;
  endfunction

  function automatic zt_t zall(input logic [17:0] v);
    zt_t r;
    for (int i = 0; i < NS; i++) r[i / SIZE][i % SIZE] = v;
    return r;
  endfunction

  // Reference model: apply each accepted tile in order, clears take effect at the request.
  always @(negedge clk) begin
    if (rst) begin
      if (in_valid && in_ready) begin
        trk_a = int'(in_tile_y) * TX + int'(in_tile_x);
        trk_e.tx = in_tile_x;
        trk_e.ty = in_tile_y;
        trk_e.z = in_z;
        trk_e.mask = '0;
        trk_e.acc = cyc;
        trk_e.lat = lat_next;
        for (int i = 0; i < NS; i++) begin
          if (in_cover[i / SIZE][i % SIZE] && closer(in_z[i / SIZE][i % SIZE], ref_buf[trk_a][i])) begin
            trk_e.mask[i / SIZE][i % SIZE] = 1'b1;
            ref_buf[trk_a][i] = in_z[i / SIZE][i % SIZE];
          end
        end
        q.push_back(trk_e);
      end
      if (clear_req && !busy) model_fill(clear_val);
    end
  end

  // Monitor: every presented result must equal the scoreboard head until it is taken.
  always @(negedge clk) begin
    if (rst && mon_en && out_valid) begin
      if (q.size() == 0) begin
        check("out_unexpected", q.size(), 1);
      end else begin
        check("out_mask", out_mask, q[0].mask);
        check("out_z", out_z, q[0].z);
        check("out_tile_x", out_tile_x, q[0].tx);
        check("out_tile_y", out_tile_y, q[0].ty);
        if (q[0].lat && !front_seen) check("latency", cyc - q[0].acc, 2);
        front_seen = 1'b1;
        if (out_ready) begin
          void'(q.pop_front());
          front_seen = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int tx, input int ty, input zt_t z, input mt_t cov);
    int n;
    in_valid = 1'b1;
    in_tile_x = 2'(tx);
    in_tile_y = 2'(ty);
    in_z = z;
    in_cover = cov;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready || n >= 200) break;
      n++;
    end
    if (n >= 200) check("send_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    idle();
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", q.size(), 0);
    tick();
  endtask

  task automatic clear_window(output int n, output int dn, output bit bad);
    n = 0;
    dn = 0;
    bad = 1'b0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (clear_done) dn++;
      if (busy && in_ready) bad = 1'b1;
    end
  endtask

  task automatic apply_reset();
    #1;
    rst = 1'b0;
    mon_en = 1'b0;
    idle();
    clear_req = 1'b0;
    out_ready = 1'b1;
    q.delete();
    front_seen = 1'b0;
    model_fill(18'h3FFFF);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_mask", out_mask, 0);
    check("rst_out_z", out_z, 0);
    check("rst_out_tile_x", out_tile_x, 0);
    check("rst_out_tile_y", out_tile_y, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_clear_done", clear_done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic reset_and_clear();
    int n, dn;
    bit bad;
    apply_reset();
    clear_window(n, dn, bad);
    check("clear_cycles", n, 16);
    check("clear_done_pulse", dn, 1);
    check("clear_in_ready_low", bad, 0);
    check("run_in_ready", in_ready, 1);
    tick();
    check("clear_done_single", clear_done, 0);
  endtask

  initial begin
    int n, dn;
    bit bad;
    model_fill(18'h3FFFF);
    reset_and_clear();

    // First tile, unstalled latency
    lat_next = 1'b1;
    send(1, 2, zall(18'h00800), 4'hF);
    lat_next = 1'b0;
    wait_drain();

    // Back-to-back same tile
    send(2, 1, zall(18'h00800), 4'hF);
    send(2, 1, {18'h01000, 18'h01000, 18'h01000, 18'h00400}, 4'hF);
    wait_drain();

    // Backpressure with three offered transactions
    out_ready = 1'b0;
    fork
      begin
        send(0, 0, zall(18'h00700), 4'hF);
        send(0, 0, zall(18'h00600), 4'b0011);
        send(3, 0, zall(18'h00500), 4'hF);
        idle();
      end
      begin
        repeat (5) tick();
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Clear request with two in flight
    send(0, 0, zall(18'h00800), 4'hF);
    send(3, 3, zall(18'h00800), 4'hF);
    idle();
    clear_req = 1'b1;
    clear_val = 18'h00100;
    tick();
    clear_req = 1'b0;
    clear_window(n, dn, bad);
    check("req_clear_busy_range", (n >= 16 && n <= 20), 1);
    check("req_clear_done", dn, 1);
    check("req_inflight_done", q.size(), 0);
    send(1, 1, zall(18'h00100), 4'hF);
    send(1, 1, zall(18'h000FF), 4'hF);
    wait_drain();

    // Partial coverage
    send(2, 2, zall(18'h00080), 4'b0101);
    send(2, 2, zall(18'h00080), 4'hF);
    wait_drain();

    // Randomized traffic with backpressure and occasional clears
    for (int it = 0; it < 400; it++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_tile_x = 2'($urandom_range(0, 1));
      in_tile_y = 2'($urandom_range(0, 1));
      for (int i = 0; i < NS; i++) in_z[i / SIZE][i % SIZE] = 18'($urandom_range(0, 'h3FF));
      in_cover = 4'($urandom_range(0, 15));
      clear_req = ($urandom_range(0, 59) == 0);
      clear_val = 18'($urandom_range(0, 'h3FF));
      tick();
    end
    clear_req = 1'b0;
    wait_drain();
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("random_settle", busy, 0);

    // Reset while a result is held
    out_ready = 1'b0;
    send(0, 1, zall(18'h00010), 4'hF);
    idle();
    tick();
    check("pre_reset_valid", out_valid, 1);
    reset_and_clear();

    // Reset in the middle of a requested clear
    clear_req = 1'b1;
    clear_val = 18'h00050;
    tick();
    clear_req = 1'b0;
    repeat (6) tick();
    check("mid_clear_busy", busy, 1);
    reset_and_clear();
    send(0, 1, zall(18'h20000), 4'hF);
    send(3, 3, zall(18'h3FFFE), 4'hF);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_chk);
    $fatal(1, "timeout");
  end

endmodule
